data_mem_resp: RTL

//  Memory responder at the far end of the address path driven by mem_addr_sel.

---
 rtl/data_mem_resp_pkg.sv | 51 +++++
 rtl/data_mem_resp_ram.sv | 32 +++
 rtl/data_mem_resp.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_resp_pkg.sv
// Shared definitions for the data memory responder: funct3 codes, FSM states
// and the access-size helpers used by the alignment logic.
package data_mem_resp_pkg;

    // RV32 load/store funct3 codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC1 = 2'd1,
        S_ACC2 = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Access size in bytes from funct3[1:0]; the 11 encoding is rejected elsewhere.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte-lane mask of an access placed at offset 0.
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // True when the access runs past the end of its word.
    function automatic logic is_split(input logic [1:0] off, input logic [1:0] sz);
        logic [2:0] last;
        last = {1'b0, off} + size_bytes(sz);
        return last > 3'd4;
    endfunction

    function automatic logic f3_valid(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_resp_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module ram_be #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;

    // Byte-enabled write and read-before-write registered read on an enabled cycle.
    // NOTE: storage and its read register have no reset; RAM contents survive reset by design.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rd_q <= mem[addr];
        end
    end

    assign rdata = rd_q;

endmodule

// File: rtl/data_mem_resp.sv
// Load/store responder: accepts one request, performs it on a byte-enabled
// word RAM (splitting word-crossing accesses into two word accesses) and
// returns a single response strobe with extended load data or an error.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] w0_q, w0_d;
    logic [1:0]    off_q, off_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [31:0]   word0_q, word0_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [AW:0]   w0_in;
    logic          req_err;
    logic          split_l;
    logic [7:0]    be8;
    logic [63:0]   wd64;
    logic [63:0]   ld64;
    logic [31:0]   ld_sh;
    logic [31:0]   ld_ext;
    logic [31:0]   rsp_data;

    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_be_w;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    // Error classification of the incoming request, evaluated at the accept edge.
    always_comb begin
        w0_in   = {1'b0, addr[AW+1:2]};
        req_err = !f3_valid(funct3)
               || (we && funct3[2])
               || (addr[31:AW+2] != '0)
               || (w0_in >= DEPTH_X)
               || (is_split(addr[1:0], funct3[1:0]) && ((w0_in + (AW+1)'(1)) >= DEPTH_X));
    end

    // Alignment datapath: lane enables, shifted store data, load assembly and extension.
    always_comb begin
        split_l = is_split(off_q, f3_q[1:0]);
        be8     = {4'b0000, size_mask(f3_q[1:0])} << off_q;
        wd64    = {32'h0, wdata_q} << {off_q, 3'b000};
        // Non-split loads see their only word on the read port; split loads pair it with word0.
        ld64    = split_l ? {ram_rdata, word0_q} : {32'h0, ram_rdata};
        ld_sh   = 32'(ld64 >> {off_q, 3'b000});
        case (f3_q)
            F3_B:    ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
            F3_H:    ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
            F3_W:    ld_ext = ld_sh;
            F3_BU:   ld_ext = {24'h0, ld_sh[7:0]};
            F3_HU:   ld_ext = {16'h0, ld_sh[15:0]};
            default: ld_ext = 32'h0;
        endcase
        rsp_data = (err_q || we_q) ? 32'h0 : ld_ext;
    end

    // Next-state and RAM control; every target gets a default first.
    // NOTE: assigning defaults before the case keeps this block free of inferred latches.
    always_comb begin
        state_d   = state_q;
        w0_d      = w0_q;
        off_d     = off_q;
        we_d      = we_q;
        f3_d      = f3_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        word0_d   = word0_q;
        rdata_d   = rdata_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_en    = 1'b0;
        ram_addr  = w0_q;
        ram_be_w  = 4'b0000;
        ram_wdata = wd64[31:0];
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w0_d    = addr[AW+1:2];
                    off_d   = addr[1:0];
                    we_d    = we;
                    f3_d    = funct3;
                    wdata_d = wdata;
                    err_d   = req_err;
                    state_d = req_err ? S_RESP : S_ACC1;
                end
            end
            S_ACC1: begin
                ram_en   = 1'b1;
                ram_be_w = we_q ? be8[3:0] : 4'b0000;
                state_d  = split_l ? S_ACC2 : S_RESP;
            end
            S_ACC2: begin
                word0_d   = ram_rdata;
                ram_en    = 1'b1;
                ram_addr  = w0_q + AW'(1);
                ram_be_w  = we_q ? be8[7:4] : 4'b0000;
                ram_wdata = wd64[63:32];
                state_d   = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rdata_d   = rsp_data;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers; reset drops any operation in flight.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            w0_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            word0_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            w0_q    <= w0_d;
            off_q   <= off_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            word0_q <= word0_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rsp_valid ? rsp_data : rdata_q;
    assign err   = rsp_valid & err_q;

    ram_be #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .addr  (ram_addr),
        .be    (ram_be_w),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
